// File: rtl/stereo_mix_sequencer.sv
// rtl/stereo_mix_sequencer.sv - time-multiplexed stereo mixer, one channel accumulated per Clk
// Per-channel pan/volume, saturated offset-binary stereo output once per NCH+1 cycle frame.
module stereo_mix_sequencer #(
  parameter int NCH   = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 9,
  parameter int VOL_W = 4,
  parameter int ATTN  = 2,
  localparam int AW   = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic [NCH*IN_W-1:0]   ch_data,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [VOL_W+1:0]      cfg_wdata,
  output logic [VOL_W+1:0]      cfg_rdata,
  output logic [OUT_W-1:0]      out_left,
  output logic [OUT_W-1:0]      out_right,
  output logic                  out_valid
);

  localparam int CW    = VOL_W + 2;
  localparam int PW    = IN_W + VOL_W + 2;
  localparam int ACC_W = IN_W + VOL_W + $clog2(NCH) + 1;

  localparam logic [CW-1:0]           CFG_RST = {2'b11, VOL_W'(1 << (VOL_W - 1))};
  localparam logic [IN_W:0]           IN_MID  = (IN_W + 1)'(1 << (IN_W - 1));
  localparam logic [OUT_W-1:0]        OUT_MID = OUT_W'(1 << (OUT_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  localparam logic [AW:0]             NCH_L   = (AW + 1)'(NCH);
  localparam logic [AW-1:0]           K_LAST  = AW'(NCH - 1);

  typedef enum logic {S_ACC, S_FIN} state_t;

  state_t                   state;
  logic [AW-1:0]            k;
  logic [CW-1:0]            cfg_q [NCH];
  logic signed [ACC_W-1:0]  acc_l, acc_r;

  logic                     addr_ok;
  logic [IN_W-1:0]          smp;
  logic [CW-1:0]            cur_cfg;
  logic signed [IN_W:0]     s;
  logic signed [PW-1:0]     prod, p;
  logic signed [ACC_W-1:0]  p_ext, p_l, p_r;

  assign addr_ok   = {1'b0, cfg_addr} < NCH_L;
  assign cfg_rdata = addr_ok ? cfg_q[cfg_addr] : '0;

  // Contribution of the channel currently addressed by the sequencer
  assign smp     = ch_data[k*IN_W +: IN_W];
  assign cur_cfg = cfg_q[k];
  assign s       = $signed({1'b0, smp} - IN_MID);
  assign prod    = s * $signed({1'b0, cur_cfg[VOL_W-1:0]});
  assign p       = prod >>> (VOL_W - 1);
  assign p_ext   = ACC_W'(p);
  assign p_l     = cur_cfg[CW-1] ? p_ext : '0;
  assign p_r     = cur_cfg[CW-2] ? p_ext : '0;

  function automatic logic [OUT_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> ATTN;
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return OUT_W'(r) + OUT_MID;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NCH; i++) cfg_q[i] <= CFG_RST;
      state     <= S_ACC;
      k         <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_left  <= OUT_MID;
      out_right <= OUT_MID;
      out_valid <= 1'b0;
    end else begin
      if (cfg_we && addr_ok) cfg_q[cfg_addr] <= cfg_wdata;
      out_valid <= 1'b0;
      if (!enable) begin
        state <= S_ACC;
        k     <= '0;
      end else begin
        case (state)
          S_ACC: begin
            acc_l <= (k == '0) ? p_l : acc_l + p_l;
            acc_r <= (k == '0) ? p_r : acc_r + p_r;
            if (k == K_LAST) state <= S_FIN;
            else             k     <= k + 1'b1;
          end
          S_FIN: begin
            out_left  <= to_out(acc_l);
            out_right <= to_out(acc_r);
            out_valid <= 1'b1;
            state     <= S_ACC;
            k         <= '0;
          end
          default: begin
            state <= S_ACC;
            k     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stereo_mix_sequencer.sv
// tb/tb_stereo_mix_sequencer.sv - self-checking bench for stereo_mix_sequencer
// Frame-level arithmetic model of the mix; random and directed frames.
module tb_stereo_mix_sequencer;
  localparam int NCH = 8;

  logic         Clk;
  logic         Reset;
  logic         enable;
  logic [63:0]  ch_data;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [5:0]   cfg_wdata;
  logic [5:0]   cfg_rdata;
  logic [8:0]   out_left;
  logic [8:0]   out_right;
  logic         out_valid;

  int asserts  = 0;
  int failures = 0;
  int m_pan [NCH];
  int m_vol [NCH];
  int m_data[NCH];

  stereo_mix_sequencer dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .ch_data(ch_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    asserts++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected offset-binary output for one side (1 = left, 0 = right)
  function automatic int exp_out(input int side);
    int sum = 0;
    int r;
    for (int i = 0; i < NCH; i++)
      if (((m_pan[i] >> side) & 1) != 0)
        sum += ((m_data[i] - 128) * m_vol[i]) >>> 3;
    r = sum >>> 2;
    if (r > 255)  r = 255;
    if (r < -256) r = -256;
    return r + 256;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pan[i] = 3;
      m_vol[i] = 8;
    end
  endtask

  task automatic apply_data();
    for (int i = 0; i < NCH; i++) ch_data[i*8 +: 8] = 8'(m_data[i]);
  endtask

  task automatic cfg_write(input int addr, input int pan, input int vol);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(addr);
    cfg_wdata = 6'((pan << 4) | vol);
    tick();
    cfg_we    = 1'b0;
    if (addr < NCH) begin
      m_pan[addr] = pan;
      m_vol[addr] = vol;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_left"},  int'(out_left),  exp_out(1));
    check_eq({tag, "_right"}, int'(out_right), exp_out(0));
  endtask

  // Pause the sequencer, program every channel from the model, then run one full frame
  task automatic do_frame(input string tag);
    int n;
    enable = 1'b0;
    for (int i = 0; i < NCH; i++) cfg_write(i, m_pan[i], m_vol[i]);
    apply_data();
    enable = 1'b1;
    wait_valid(n);
    check_eq({tag, "_latency"}, n, 9);
    check_outputs(tag);
  endtask

  initial begin
    int n;
    int hold_l, hold_r, bad_valid;

    Reset = 1'b1; enable = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    for (int i = 0; i < NCH; i++) m_data[i] = 128;
    apply_data();
    tick(); tick();
    check_eq("rst_left", int'(out_left), 256);
    check_eq("rst_right", int'(out_right), 256);
    check_eq("rst_valid", int'(out_valid), 0);
    for (int i = 0; i < NCH; i += 3) begin
      cfg_addr = 3'(i);
      #1 check_eq("rst_cfg_rdata", int'(cfg_rdata), 6'b111000);
    end

    Reset = 1'b0;
    wait_valid(n);
    check_eq("first_valid_latency", n, 9);
    check_eq("mid_left", int'(out_left), 256);
    check_eq("mid_right", int'(out_right), 256);
    wait_valid(n);
    check_eq("valid_period", n, 9);

    m_data[0] = 255; m_pan[0] = 2; m_vol[0] = 8;
    do_frame("ch0_left_only");
    check_eq("ch0_left_const", int'(out_left), 287);

    for (int i = 0; i < NCH; i++) begin m_data[i] = 255; m_pan[i] = 3; m_vol[i] = 15; end
    do_frame("sat_high");
    check_eq("sat_high_const", int'(out_left), 511);
    for (int i = 0; i < NCH; i++) m_data[i] = 0;
    do_frame("sat_low");
    check_eq("sat_low_const", int'(out_right), 0);

    model_reset();
    for (int i = 0; i < NCH; i++) m_data[i] = 128;
    m_data[3] = 200; m_pan[3] = 0;
    do_frame("pan_zero");
    m_pan[3] = 3; m_vol[3] = 0;
    do_frame("vol_zero");

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NCH; i++) begin
        m_data[i] = int'($urandom_range(0, 255));
        m_pan[i]  = int'($urandom_range(0, 3));
        m_vol[i]  = int'($urandom_range(0, 15));
      end
      do_frame("random");
    end

    // Reset landing on channel 4 discards the frame and restores default configs
    wait_valid(n);
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b1;
    tick();
    check_eq("midrst_left", int'(out_left), 256);
    check_eq("midrst_right", int'(out_right), 256);
    check_eq("midrst_valid", int'(out_valid), 0);
    model_reset();
    cfg_addr = 3'd6;
    #1 check_eq("midrst_cfg", int'(cfg_rdata), 6'b111000);
    Reset = 1'b0;
    wait_valid(n);
    check_eq("midrst_latency", n, 9);
    check_outputs("midrst_frame");

    // Write to channel 2 in the same cycle as its accumulation
    for (int i = 0; i < NCH; i++) m_data[i] = int'($urandom_range(0, 255));
    m_data[2] = 255;
    apply_data();
    tick(); tick();
    hold_l = exp_out(1);
    hold_r = exp_out(0);
    cfg_write(2, 1, 15);
    wait_valid(n);
    check_eq("samecyc_latency", n, 6);
    check_eq("samecyc_old_left", int'(out_left), hold_l);
    check_eq("samecyc_old_right", int'(out_right), hold_r);
    wait_valid(n);
    check_eq("samecyc_next_period", n, 9);
    check_outputs("samecyc_new");

    // Drop enable at channel 5 for 20 cycles
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    hold_l = int'(out_left);
    hold_r = int'(out_right);
    bad_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || int'(out_left) != hold_l || int'(out_right) != hold_r) bad_valid++;
    end
    check_eq("disabled_hold_cycles", bad_valid, 0);
    for (int i = 0; i < NCH; i++) m_data[i] = int'($urandom_range(0, 255));
    apply_data();
    enable = 1'b1;
    wait_valid(n);
    check_eq("reenable_latency", n, 9);
    check_outputs("reenable_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/stereo_mix_sequencer.md
Name: stereo_mix_sequencer

Overview:
Parametrised, time-multiplexed stereo mixer for NCH unsigned offset-binary sound sources (AY channels, beeper, specdrum, sampler voices).
- Each channel has a CPU-programmable 2-bit pan and a VOL_W-bit volume.
- One channel is accumulated per Clk; each frame ends with a saturated, offset-binary stereo sample and a valid strobe.
- Sits between the sound sources and the per-side sigma-delta DACs. Generalises the fixed 8-source on/off panner with per-channel gain, saturation and any channel count.

Parameters:
NCH, 8, number of input channels (>=2)
IN_W, 8, channel sample width, unsigned offset binary (midpoint 2^(IN_W-1))
OUT_W, 9, output sample width, unsigned offset binary
VOL_W, 4, per-channel volume width; unity gain = 2^(VOL_W-1)
ATTN, 2, arithmetic right shift applied to the accumulated sum before saturation

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
enable  in  1  run the mix sequencer
ch_data  in  NCH*IN_W  flattened samples; channel i = ch_data[i*IN_W +: IN_W]
cfg_we  in  1  write strobe for a channel config register
cfg_addr  in  AW=max(1,clog2(NCH))  channel index for write/read
cfg_wdata  in  VOL_W+2  {pan[1:0], vol[VOL_W-1:0]}; pan bit1 = left, bit0 = right
cfg_rdata  out  VOL_W+2  config of channel cfg_addr (combinational)
out_left  out  OUT_W  left sample, offset binary
out_right  out  OUT_W  right sample, offset binary
out_valid  out  1  one-cycle strobe when out_left/out_right update

Behaviour:
- Reset (synchronous, Reset high at a Clk edge):
  - all config registers = {2'b11, 2^(VOL_W-1)} (both sides, unity gain)
  - out_left = out_right = 2^(OUT_W-1); out_valid = 0
  - accumulators = 0; sequencer = ACC, channel counter = 0
  - Reset dominates enable and cfg_we; asserting it mid-frame discards the partial frame.
- Config write: cfg_we at a Clk edge with cfg_addr < NCH updates that register. Writes with cfg_addr >= NCH are ignored; reads with cfg_addr >= NCH return 0.
- Sequencer states, frame length NCH+1 cycles:
  - ACC, counter k = 0..NCH-1:
    - s = ch_data[k] - 2^(IN_W-1), signed IN_W+1 bits
    - p = (s * vol[k]) >>> (VOL_W-1), arithmetic shift
    - if pan[k][1], accL += p; if pan[k][0], accR += p
    - at k == 0, the accumulators are loaded with p (or 0) instead of added to
    - ch_data[k] and config[k] are sampled at that cycle's edge; a write to channel k in the same cycle as its ACC takes effect next frame
  - FIN:
    - per side: r = acc >>> ATTN, saturated to signed OUT_W, i.e. [-2^(OUT_W-1), 2^(OUT_W-1)-1]
    - out = r + 2^(OUT_W-1)
    - out_valid = 1 for this single cycle; next state ACC, k = 0
- Accumulator width = IN_W+VOL_W+clog2(NCH)+1, so no internal overflow at any input/volume. Saturation happens only at FIN.
- Latency: a sample on channel k reaches the outputs NCH-k cycles after its ACC edge.
- enable low: sequencer forced to ACC with k = 0 and the partial frame discarded; outputs hold last value; out_valid = 0; config writes still accepted. Re-enabling starts a fresh frame at channel 0.
- vol = 0 or pan = 00 contributes exactly 0. A frame with all contributions 0 outputs the midpoint.
- out_valid period with enable held high: exactly NCH+1 cycles.

Test Plan:
Test parameters: defaults (NCH=8, IN_W=8, OUT_W=9, VOL_W=4, ATTN=2).
1. Reset, enable=1, all ch_data=128 -> first out_valid 9 cycles after Reset release; out_left = out_right = 256; out_valid repeats every 9 cycles; cfg_rdata of any channel = 6'b111000.
2. ch0=255, others 128, cfg ch0 = {10, 8} -> out_left = 256+(127>>>2) = 287; out_right = 256.
3. All ch=255, all vol=15, pan=11 -> per-channel p = 238, sum 1904, >>>2 = 476, saturates -> both outputs 511. All ch=0 -> p = -240, sum -1920, >>>2 = -480 -> both outputs 0.
4. Pan/volume zero and bad address:
   - ch3=200 with pan=00, then with vol=0 -> both outputs 256 in both cases
   - cfg_we with cfg_addr >= NCH (AW-bit space) -> no register changes
5. Mid-operation events:
   - Reset asserted at k=4 -> next cycle outputs 256, out_valid 0, configs default; next out_valid 9 cycles after Reset release
   - Write to ch2 in the same cycle as its ACC -> old config used this frame, new config next frame
6. enable dropped at k=5 for 20 cycles -> outputs hold, no out_valid. Re-enable -> out_valid exactly 9 cycles later with a full-frame result.
